// File: rtl/mod_rkbuf_pkg.sv
// Shared AES constants and round-key buffer state encoding.
package mod_rkbuf_pkg;

    localparam int AES_NR     = 14;
    localparam int AES_NB     = 4;
    localparam int AES_NWORDS = AES_NB * (AES_NR + 1);

    typedef enum logic [1:0] {
        RK_IDLE  = 2'd0,
        RK_LOAD  = 2'd1,
        RK_READY = 2'd2
    } rk_state_t;

endpackage

// File: rtl/mod_rkbuf_mem.sv
// Round-key storage: NR+1 entries of NB*32 bits, one 32-bit lane write port,
// one registered read port that returns zero when not enabled.
module mod_rkbuf_mem #(
    parameter int NR = 14,
    parameter int NB = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [3:0]        wr_round_i,
    input  logic [1:0]        wr_lane_i,
    input  logic [31:0]       wr_data_i,
    input  logic              rd_en_i,
    input  logic [3:0]        rd_round_i,
    output logic [NB*32-1:0]  rd_data_o
);

    logic [NB*32-1:0] mem_q [NR+1];
    logic [NB*32-1:0] rd_data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r <= NR; r++) begin
                mem_q[r] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            // Lane 0 lands in the most significant word.
            if (wr_en_i) begin
                mem_q[wr_round_i][(NB-1-int'(wr_lane_i))*32 +: 32] <= wr_data_i;
            end
            rd_data_q <= rd_en_i ? mem_q[rd_round_i] : '0;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mod_rkbuf.sv
// Round-key buffer: packs expanded key words into round keys and serves reads.
// Optional reverse-order reads via rk_inv when RKBUF_INV_ORDER_EN is defined.
module mod_rkbuf
    import mod_rkbuf_pkg::*;
#(
    parameter int NR = AES_NR,
    parameter int NB = AES_NB
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rk_start,
    input  logic              kg_valid,
    input  logic [31:0]       kg_word,
    input  logic              rk_rdEn,
    input  logic [3:0]        rk_rdAddr,
`ifdef RKBUF_INV_ORDER_EN
    input  logic              rk_inv,
`endif
    output logic [NB*32-1:0]  rk_dataOut,
    output logic              rk_dataValid,
    output logic [3:0]        rk_count,
    output logic              rk_ready,
    output logic              rk_err
);

    localparam logic [5:0] LAST_WORD = 6'(NB*(NR+1) - 1);
    localparam logic [1:0] LAST_LANE = 2'(NB - 1);

    rk_state_t  state_q, state_d;
    logic [5:0] wcnt_q, wcnt_d;
    logic [3:0] count_q, count_d;
    logic       ready_q, ready_d;
    logic       err_q, err_d;
    logic       valid_q;

    logic       wr_en;
    logic [3:0] wr_round;
    logic [1:0] wr_lane;
    logic [3:0] rd_round;
    logic       rd_ok;

    assign wr_round = 4'(wcnt_q / NB);
    assign wr_lane  = 2'(wcnt_q % NB);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RK_IDLE;
            wcnt_q  <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            count_q <= count_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            valid_q <= rd_ok;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        count_d = count_q;
        ready_d = ready_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        // A start pulse wins over a coincident word, which is dropped.
        if (rk_start) begin
            state_d = RK_LOAD;
            wcnt_d  = '0;
            count_d = '0;
            ready_d = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                RK_IDLE: ;
                RK_LOAD: begin
                    if (kg_valid) begin
                        wr_en  = 1'b1;
                        wcnt_d = wcnt_q + 6'd1;
                        if (wr_lane == LAST_LANE) begin
                            count_d = count_q + 4'd1;
                        end
                        if (wcnt_q == LAST_WORD) begin
                            state_d = RK_READY;
                            ready_d = 1'b1;
                        end
                    end
                end
                RK_READY: begin
                    if (kg_valid) begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = RK_IDLE;
            endcase
        end
    end

`ifdef RKBUF_INV_ORDER_EN
    assign rd_round = rk_inv ? (4'(NR) - rk_rdAddr) : rk_rdAddr;
`else
    assign rd_round = rk_rdAddr;
`endif

    // Uses the pre-edge count, so a round completing this cycle reads as invalid.
    assign rd_ok = rk_rdEn && (rk_rdAddr <= 4'(NR)) && (rd_round < count_q);

    mod_rkbuf_mem #(
        .NR(NR),
        .NB(NB)
    ) u_mem (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (wr_en),
        .wr_round_i (wr_round),
        .wr_lane_i  (wr_lane),
        .wr_data_i  (kg_word),
        .rd_en_i    (rd_ok),
        .rd_round_i (rd_round),
        .rd_data_o  (rk_dataOut)
    );

    assign rk_dataValid = valid_q;
    assign rk_count     = count_q;
    assign rk_ready     = ready_q;
    assign rk_err       = err_q;

endmodule

// File: tb/tb_mod_rkbuf.sv
// Directed bench for mod_rkbuf: load, early reads, restart, overflow, async reset.
module tb_mod_rkbuf;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         rk_start = 1'b0;
    logic         kg_valid = 1'b0;
    logic [31:0]  kg_word = '0;
    logic         rk_rdEn = 1'b0;
    logic [3:0]   rk_rdAddr = '0;
`ifdef RKBUF_INV_ORDER_EN
    logic         rk_inv = 1'b0;
`endif
    logic [127:0] rk_dataOut;
    logic         rk_dataValid;
    logic [3:0]   rk_count;
    logic         rk_ready;
    logic         rk_err;

    int errors = 0;
    int checks = 0;

    mod_rkbuf dut (
        .clk          (clk),
        .reset        (reset),
        .rk_start     (rk_start),
        .kg_valid     (kg_valid),
        .kg_word      (kg_word),
        .rk_rdEn      (rk_rdEn),
        .rk_rdAddr    (rk_rdAddr),
`ifdef RKBUF_INV_ORDER_EN
        .rk_inv       (rk_inv),
`endif
        .rk_dataOut   (rk_dataOut),
        .rk_dataValid (rk_dataValid),
        .rk_count     (rk_count),
        .rk_ready     (rk_ready),
        .rk_err       (rk_err)
    );

    always #5 clk = ~clk;

    // FIPS-197 AES-256 words where known; the buffer stores words verbatim,
    // so the remaining words use a distinct synthetic pattern.
    function automatic logic [31:0] word_of(input int i);
        logic [7:0] b;
        b = 8'(4 * i);
        case (i)
            8:  return 32'ha573c29f;
            9:  return 32'ha176c498;
            10: return 32'ha97fce93;
            11: return 32'ha572c09c;
            56: return 32'h24fc79cc;
            57: return 32'hbf0979e9;
            58: return 32'h371ac23c;
            59: return 32'h6d68de36;
            default: begin
                if (i < 8) return {b, b + 8'd1, b + 8'd2, b + 8'd3};
                return {8'(i), ~8'(i), 8'ha5, 8'(i * 3)};
            end
        endcase
    endfunction

    function automatic logic [127:0] round_of(input int r);
        return {word_of(4*r), word_of(4*r+1), word_of(4*r+2), word_of(4*r+3)};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic st, input logic vld, input logic [31:0] w,
                       input logic rd, input logic [3:0] addr);
        rk_start  = st;
        kg_valid  = vld;
        kg_word   = w;
        rk_rdEn   = rd;
        rk_rdAddr = addr;
        @(posedge clk);
        #1;
        rk_start  = 1'b0;
        kg_valid  = 1'b0;
        kg_word   = '0;
        rk_rdEn   = 1'b0;
        rk_rdAddr = '0;
    endtask

    task automatic stream(input int first, input int last);
        for (int i = first; i <= last; i++) cyc(1'b0, 1'b1, word_of(i), 1'b0, 4'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] addr,
                          input logic exp_v, input logic [127:0] exp_d);
        cyc(1'b0, 1'b0, '0, 1'b1, addr);
        chk({tag, "_valid"}, 128'(rk_dataValid), 128'(exp_v));
        chk({tag, "_data"}, rk_dataOut, exp_d);
    endtask

    initial begin
        #1 reset = 1'b1;
        #1;
        chk("rst_data", rk_dataOut, '0);
        chk("rst_valid", 128'(rk_dataValid), 128'(0));
        chk("rst_count", 128'(rk_count), 128'(0));
        chk("rst_ready", 128'(rk_ready), 128'(0));
        chk("rst_err", 128'(rk_err), 128'(0));
        #20 reset = 1'b0;

        rd_chk("idle_rd0", 4'd0, 1'b0, '0);
        cyc(1'b0, 1'b1, 32'hdeadbeef, 1'b0, 4'd0);
        chk("idle_ignore_count", 128'(rk_count), 128'(0));

        // Load with early reads.
        cyc(1'b1, 1'b0, '0, 1'b0, 4'd0);
        stream(0, 7);
        chk("cnt_after8", 128'(rk_count), 128'(2));
        rd_chk("early_rd2", 4'd2, 1'b0, '0);
        cyc(1'b0, 1'b0, '0, 1'b0, 4'd0);
        chk("novalid_idle_cycle", 128'(rk_dataValid), 128'(0));
        rd_chk("early_rd1", 4'd1, 1'b1, 128'h101112131415161718191a1b1c1d1e1f);
        stream(8, 10);
        cyc(1'b0, 1'b1, word_of(11), 1'b1, 4'd2);
        chk("same_cycle_valid", 128'(rk_dataValid), 128'(0));
        chk("same_cycle_data", rk_dataOut, '0);
        rd_chk("after11_rd2", 4'd2, 1'b1, 128'ha573c29fa176c498a97fce93a572c09c);
        stream(12, 58);
        chk("cnt_after59", 128'(rk_count), 128'(14));
        chk("ready_before_last", 128'(rk_ready), 128'(0));
        stream(59, 59);
        chk("ready_after_last", 128'(rk_ready), 128'(1));
        chk("cnt_full", 128'(rk_count), 128'(15));
        rd_chk("full_rd0", 4'd0, 1'b1, 128'h000102030405060708090a0b0c0d0e0f);
        rd_chk("full_rd14", 4'd14, 1'b1, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        rd_chk("full_rd15", 4'd15, 1'b0, '0);
        for (int r = 0; r <= 14; r++) rd_chk($sformatf("full_r%0d", r), 4'(r), 1'b1, round_of(r));

`ifdef RKBUF_INV_ORDER_EN
        rk_inv = 1'b1;
        rd_chk("inv_rd0", 4'd0, 1'b1, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        rd_chk("inv_rd14", 4'd14, 1'b1, 128'h000102030405060708090a0b0c0d0e0f);
        rd_chk("inv_rd15", 4'd15, 1'b0, '0);
        rk_inv = 1'b0;
`endif

        // Overflow in READY.
        cyc(1'b0, 1'b1, 32'hffffffff, 1'b0, 4'd0);
        chk("ovf_err", 128'(rk_err), 128'(1));
        chk("ovf_count", 128'(rk_count), 128'(15));
        rd_chk("ovf_rd14", 4'd14, 1'b1, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        rd_chk("ovf_rd0", 4'd0, 1'b1, 128'h000102030405060708090a0b0c0d0e0f);
        cyc(1'b1, 1'b0, '0, 1'b0, 4'd0);
        chk("restart_err", 128'(rk_err), 128'(0));
        chk("restart_count", 128'(rk_count), 128'(0));
        chk("restart_ready", 128'(rk_ready), 128'(0));

        // Start coincident with word 30, then gappy reload.
        stream(0, 29);
        chk("pre_restart_count", 128'(rk_count), 128'(7));
        cyc(1'b1, 1'b1, word_of(30), 1'b0, 4'd0);
        chk("coinc_count", 128'(rk_count), 128'(0));
        chk("coinc_ready", 128'(rk_ready), 128'(0));
        rd_chk("coinc_rd0", 4'd0, 1'b0, '0);
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 1) cyc(1'b0, 1'b0, 32'h5a5a5a5a, 1'b0, 4'd0);
            cyc(1'b0, 1'b1, word_of(i), 1'b0, 4'd0);
        end
        chk("gap_ready", 128'(rk_ready), 128'(1));
        chk("gap_count", 128'(rk_count), 128'(15));
        for (int r = 0; r <= 14; r++) rd_chk($sformatf("gap_r%0d", r), 4'(r), 1'b1, round_of(r));

        // Async reset mid-load at word 20.
        cyc(1'b1, 1'b0, '0, 1'b0, 4'd0);
        stream(0, 19);
        chk("mid_count", 128'(rk_count), 128'(5));
        rd_chk("mid_rd1", 4'd1, 1'b1, 128'h101112131415161718191a1b1c1d1e1f);
        #2 reset = 1'b1;
        #1;
        chk("arst_data", rk_dataOut, '0);
        chk("arst_valid", 128'(rk_dataValid), 128'(0));
        chk("arst_count", 128'(rk_count), 128'(0));
        chk("arst_ready", 128'(rk_ready), 128'(0));
        chk("arst_err", 128'(rk_err), 128'(0));
        #1 reset = 1'b0;
        rd_chk("post_rst_rd0", 4'd0, 1'b0, '0);
        stream(20, 23);
        chk("post_rst_no_load", 128'(rk_count), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
